alu_seq: RTL

Parametrised, registered successor to the 8-bit ripple add/sub ALU. It supports arithmetic, logic, shift/rotate and an iterative shift-add multiply, with a start/done handshake. It keeps a carry/zero/negative/overflow flag register, so multi-word arithmetic can chain through the stored carry. It sits between the register file operand buses and the writeback path of the datapath.

---
 rtl/alu_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with {C,Z,N,V} flags, shift-add MUL, start/done handshake; in: clk rst(async low) start op a b cin; out: result flags busy done
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBC = 4'd3,
                         OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
                         OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ROL = 4'd10, OP_ROR = 4'd11,
                         OP_MUL = 4'd12, OP_CLRF = 4'd14;
  typedef enum logic {IDLE, MUL} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, mcand_q, mcand_d, bb, alu_r;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d, alu_c, alu_v, ci, hi_nz;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step;
  logic [WIDTH:0]     sum, msum;
  always_comb begin
    bb = op[0] ? ~b : b;
    ci = op[1] ? flags_q[3] : cin;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    alu_r = a;
    alu_c = flags_q[3];
    alu_v = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_NOT: alu_r = ~a;
      OP_SHL: {alu_c, alu_r} = {a, 1'b0};
      OP_SHR: {alu_r, alu_c} = {1'b0, a};
      OP_ROL: {alu_c, alu_r} = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR: {alu_c, alu_r} = {a[0], a[0], a[WIDTH-1:1]};
      default: alu_v = flags_q[0];
    endcase
  end
  always_comb begin
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step = {msum, acc_q[WIDTH-1:1]};
    hi_nz = |step[2*WIDTH-1:WIDTH];
  end
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    flags_d = flags_q;
    done_d = 1'b0;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    if (state_q == IDLE && start) begin
      if (op == OP_MUL) begin
        state_d = MUL;
        cnt_d = CW'(WIDTH);
        acc_d = {{WIDTH{1'b0}}, b};
        mcand_d = a;
      end else if (op == OP_CLRF) begin
        flags_d = 4'b0000;
        done_d = 1'b1;
      end else begin
        result_d = alu_r;
        flags_d = {alu_c, alu_r == '0, alu_r[WIDTH-1], alu_v};
        done_d = 1'b1;
      end
    end else if (state_q == MUL) begin
      acc_d = step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        result_d = step[WIDTH-1:0];
        flags_d = {hi_nz, step[WIDTH-1:0] == '0, step[WIDTH-1], hi_nz};
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      result_q <= '0;
      flags_q <= '0;
      done_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      flags_q <= flags_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
    end
  end
  assign result = result_q;
  assign flags = flags_q;
  assign done = done_q;
  assign busy = state_q == MUL;
endmodule
